// File: rtl/best_1ofn_cclut_pipe_pkg.sv
// Shared pattern-word parameters and helpers for the best-of-N ccLUT sorter.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package best_1ofn_cclut_pipe_pkg;

    localparam int MXPATB = 7;   // pattern word width, lsb is bend direction
    localparam int MXPATC = 12;  // ccLUT comparator-code carry width
    localparam int MXKEYB = 5;   // key width, 2^MXKEYB candidates

    // Default register placement: one register after stage 3 plus the output register.
    localparam logic [MXKEYB-1:0] DEF_REG_MASK = 5'b01000;

    // Quality used for sorting: drop the bend-direction lsb.
    function automatic logic [MXPATB-2:0] sort_field(input logic [MXPATB-1:0] pat);
        return pat[MXPATB-1:1];
    endfunction

    // Entry offset of tree level lvl inside a flattened tree bus.
    // Level 0 holds nin entries, level l holds nin>>l entries.
    function automatic int lvl_off(input int nin, input int lvl);
        return 2 * nin - 2 * (nin >> lvl);
    endfunction

endpackage

// File: rtl/best_1ofn_cclut_pipe_best_of2_node.sv
// Compare-by-twos node: picks the better of an even/odd candidate pair.
// Latency: purely combinational, 0 clocks.
// Backpressure: none; evaluates every cycle.
module best_of2_node #(
    parameter int MXPATB = 7,
    parameter int MXPATC = 12,
    parameter int KW     = 5,
    parameter int STAGE  = 0
) (
    input  logic              tie_hi,
    input  logic [MXPATB-1:0] pat_lo,
    input  logic [MXPATB-1:0] pat_hi,
    input  logic [MXPATC-1:0] car_lo,
    input  logic [MXPATC-1:0] car_hi,
    input  logic [KW-1:0]     key_lo,
    input  logic [KW-1:0]     key_hi,
    output logic [MXPATB-1:0] pat_o,
    output logic [MXPATC-1:0] car_o,
    output logic [KW-1:0]     key_o
);
    import best_1ofn_cclut_pipe_pkg::*;

    logic [MXPATB-2:0] q_lo;
    logic [MXPATB-2:0] q_hi;
    logic              sel_hi;

    // Higher quality wins; equal quality goes to the odd input only when tie_hi is set.
    // The winner bit lands at key position STAGE, so keys grow LSB-first.
    always_comb begin
        q_lo   = pat_lo[MXPATB-1:1];
        q_hi   = pat_hi[MXPATB-1:1];
        sel_hi = (q_hi > q_lo) || ((q_hi == q_lo) && tie_hi);
        pat_o  = sel_hi ? pat_hi : pat_lo;
        car_o  = sel_hi ? car_hi : car_lo;
        key_o  = sel_hi ? key_hi : key_lo;
        key_o[STAGE] = sel_hi;
    end

endmodule

// File: rtl/best_1ofn_cclut_pipe.sv
// Best-of-N half-strip pattern selector with configurable stage registers.
// Latency: popcount(REG_MASK)+1 clocks from in_valid to best_valid.
// Backpressure: none; accepts one candidate set every clock, never stalls.
module best_1ofn_cclut_pipe #(
    parameter int NKEYB    = best_1ofn_cclut_pipe_pkg::MXKEYB,
    parameter int MXPATB   = best_1ofn_cclut_pipe_pkg::MXPATB,
    parameter int MXPATC   = best_1ofn_cclut_pipe_pkg::MXPATC,
    parameter     REG_MASK = best_1ofn_cclut_pipe_pkg::DEF_REG_MASK
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          tie_hi,
    input  logic [(1<<NKEYB)*MXPATB-1:0]  pat_in,
    input  logic [(1<<NKEYB)*MXPATC-1:0]  carry_in,
    input  logic [MXPATB-2:0]             thresh,
    output logic                          best_valid,
    output logic                          best_found,
    output logic [MXPATB-1:0]             best_pat,
    output logic [NKEYB-1:0]              best_key,
    output logic [MXPATC-1:0]             best_carry
);
    import best_1ofn_cclut_pipe_pkg::*;

    localparam int NIN  = 1 << NKEYB;
    localparam int NTOT = 2 * NIN - 1;
    localparam int QW   = MXPATB - 1;
    localparam int FO   = lvl_off(NIN, NKEYB);

    if ($bits(REG_MASK) != NKEYB) begin : g_bad_mask
        $error("REG_MASK width must equal NKEYB");
    end

    // Flattened tree: level l occupies entries [lvl_off(l) +: NIN>>l].
    // Keys are carried full width; bits above the current stage are still zero.
    logic [NTOT*MXPATB-1:0]   lv_pat;
    logic [NTOT*MXPATC-1:0]   lv_car;
    logic [NTOT*NKEYB-1:0]    lv_key;
    logic [NKEYB:0]           lv_vld;
    logic [NKEYB-1:0]         lv_tie;
    logic [(NKEYB+1)*QW-1:0]  lv_thr;

    assign lv_pat[NIN*MXPATB-1:0] = pat_in;
    assign lv_car[NIN*MXPATC-1:0] = carry_in;
    assign lv_key[NIN*NKEYB-1:0]  = '0;
    assign lv_vld[0]              = in_valid;
    assign lv_tie[0]              = tie_hi;
    assign lv_thr[QW-1:0]         = thresh;

    for (genvar s = 0; s < NKEYB; s++) begin : g_stage
        localparam int NO = NIN >> (s + 1);
        localparam int IO = lvl_off(NIN, s);
        localparam int OO = lvl_off(NIN, s + 1);

        logic [NO*MXPATB-1:0] pat_d;
        logic [NO*MXPATC-1:0] car_d;
        logic [NO*NKEYB-1:0]  key_d;
        logic                 vld_d;
        logic [QW-1:0]        thr_d;

        for (genvar i = 0; i < NO; i++) begin : g_node
            best_of2_node #(
                .MXPATB (MXPATB),
                .MXPATC (MXPATC),
                .KW     (NKEYB),
                .STAGE  (s)
            ) u_node (
                .tie_hi (lv_tie[s]),
                .pat_lo (lv_pat[(IO+2*i)*MXPATB   +: MXPATB]),
                .pat_hi (lv_pat[(IO+2*i+1)*MXPATB +: MXPATB]),
                .car_lo (lv_car[(IO+2*i)*MXPATC   +: MXPATC]),
                .car_hi (lv_car[(IO+2*i+1)*MXPATC +: MXPATC]),
                .key_lo (lv_key[(IO+2*i)*NKEYB    +: NKEYB]),
                .key_hi (lv_key[(IO+2*i+1)*NKEYB  +: NKEYB]),
                .pat_o  (pat_d[i*MXPATB +: MXPATB]),
                .car_o  (car_d[i*MXPATC +: MXPATC]),
                .key_o  (key_d[i*NKEYB  +: NKEYB])
            );
        end

        // Valid and threshold travel alongside the data of this stage.
        always_comb begin
            vld_d = lv_vld[s];
            thr_d = lv_thr[s*QW +: QW];
        end

        if (REG_MASK[s]) begin : g_reg
            logic [NO*MXPATB-1:0] pat_q;
            logic [NO*MXPATC-1:0] car_q;
            logic [NO*NKEYB-1:0]  key_q;
            logic                 vld_q;
            logic [QW-1:0]        thr_q;

            // Stage register; reset drops any set in flight.
            always_ff @(posedge clock) begin
                if (reset) begin
                    pat_q <= '0;
                    car_q <= '0;
                    key_q <= '0;
                    vld_q <= 1'b0;
                    thr_q <= '0;
                end else begin
                    pat_q <= pat_d;
                    car_q <= car_d;
                    key_q <= key_d;
                    vld_q <= vld_d;
                    thr_q <= thr_d;
                end
            end

            assign lv_pat[OO*MXPATB +: NO*MXPATB] = pat_q;
            assign lv_car[OO*MXPATC +: NO*MXPATC] = car_q;
            assign lv_key[OO*NKEYB  +: NO*NKEYB]  = key_q;
            assign lv_vld[s+1]                    = vld_q;
            assign lv_thr[(s+1)*QW +: QW]         = thr_q;
        end else begin : g_wire
            assign lv_pat[OO*MXPATB +: NO*MXPATB] = pat_d;
            assign lv_car[OO*MXPATC +: NO*MXPATC] = car_d;
            assign lv_key[OO*NKEYB  +: NO*NKEYB]  = key_d;
            assign lv_vld[s+1]                    = vld_d;
            assign lv_thr[(s+1)*QW +: QW]         = thr_d;
        end

        // Tie mode is only needed by later stages, so the last stage has no copy.
        if (s < NKEYB - 1) begin : g_tie
            if (REG_MASK[s]) begin : g_reg
                logic tie_d;
                logic tie_q;

                // Select the tie mode that entered with this stage's set.
                always_comb begin
                    tie_d = lv_tie[s];
                end

                // Tie-mode stage register.
                always_ff @(posedge clock) begin
                    if (reset) begin
                        tie_q <= 1'b0;
                    end else begin
                        tie_q <= tie_d;
                    end
                end

                assign lv_tie[s+1] = tie_q;
            end else begin : g_wire
                assign lv_tie[s+1] = lv_tie[s];
            end
        end
    end

    logic                best_valid_d, best_valid_q;
    logic                best_found_d, best_found_q;
    logic [MXPATB-1:0]   best_pat_d,   best_pat_q;
    logic [NKEYB-1:0]    best_key_d,   best_key_q;
    logic [MXPATC-1:0]   best_carry_d, best_carry_q;

    // Tree root plus the threshold qualification, ahead of the output register.
    always_comb begin
        best_valid_d = lv_vld[NKEYB];
        best_pat_d   = lv_pat[FO*MXPATB +: MXPATB];
        best_key_d   = lv_key[FO*NKEYB  +: NKEYB];
        best_carry_d = lv_car[FO*MXPATC +: MXPATC];
        best_found_d = (best_pat_d[MXPATB-1:1] >= lv_thr[NKEYB*QW +: QW]);
    end

    // Output register, always present.
    always_ff @(posedge clock) begin
        if (reset) begin
            best_valid_q <= 1'b0;
            best_found_q <= 1'b0;
            best_pat_q   <= '0;
            best_key_q   <= '0;
            best_carry_q <= '0;
        end else begin
            best_valid_q <= best_valid_d;
            best_found_q <= best_found_d;
            best_pat_q   <= best_pat_d;
            best_key_q   <= best_key_d;
            best_carry_q <= best_carry_d;
        end
    end

    assign best_valid = best_valid_q;
    assign best_found = best_found_q;
    assign best_pat   = best_pat_q;
    assign best_key   = best_key_q;
    assign best_carry = best_carry_q;

endmodule

// File: tb/tb_best_1ofn_cclut_pipe.sv
// Bench for best_1ofn_cclut_pipe: two instances (default mask, all-registered)
// share one randomized stream and are compared every cycle to a linear-scan model.
module tb_best_1ofn_cclut_pipe;

    localparam int NKEYB  = 5;
    localparam int NIN    = 32;
    localparam int MXPATB = 7;
    localparam int MXPATC = 12;
    localparam int QW     = 6;
    localparam int LA     = 2;
    localparam int LB     = 6;
    localparam int NE     = 4096;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     tie_hi = 1'b0;
    logic [NIN*MXPATB-1:0]    pat_in = '0;
    logic [NIN*MXPATC-1:0]    carry_in = '0;
    logic [QW-1:0]            thresh = '0;

    logic                     a_valid, a_found, b_valid, b_found;
    logic [MXPATB-1:0]        a_pat, b_pat;
    logic [NKEYB-1:0]         a_key, b_key;
    logic [MXPATC-1:0]        a_carry, b_carry;

    always #5 clock = ~clock;

    best_1ofn_cclut_pipe #(.NKEYB(5), .MXPATB(7), .MXPATC(12), .REG_MASK(5'b01000)) u_dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .tie_hi(tie_hi),
        .pat_in(pat_in), .carry_in(carry_in), .thresh(thresh),
        .best_valid(a_valid), .best_found(a_found), .best_pat(a_pat),
        .best_key(a_key), .best_carry(a_carry)
    );

    best_1ofn_cclut_pipe #(.NKEYB(5), .MXPATB(7), .MXPATC(12), .REG_MASK(5'b11111)) u_dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .tie_hi(tie_hi),
        .pat_in(pat_in), .carry_in(carry_in), .thresh(thresh),
        .best_valid(b_valid), .best_found(b_found), .best_pat(b_pat),
        .best_key(b_key), .best_carry(b_carry)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: per clock edge, what the set sampled at that edge must produce.
    int             edge_cnt = 0;
    logic           h_rst [NE];
    logic           h_vld [NE];
    logic           h_fnd [NE];
    logic [6:0]     h_pat [NE];
    logic [4:0]     h_key [NE];
    logic [11:0]    h_car [NE];

    always @(posedge clock) begin
        int bk;
        int bq;
        int q;
        bk = 0;
        bq = -1;
        for (int k = 0; k < NIN; k++) begin
            q = int'(pat_in[k*MXPATB+1 +: QW]);
            if (q > bq || (q == bq && tie_hi)) begin
                bq = q;
                bk = k;
            end
        end
        if (edge_cnt < NE) begin
            h_rst[edge_cnt] <= reset;
            h_vld[edge_cnt] <= in_valid;
            h_fnd[edge_cnt] <= (bq >= int'(thresh));
            h_pat[edge_cnt] <= pat_in[bk*MXPATB +: MXPATB];
            h_key[edge_cnt] <= bk[4:0];
            h_car[edge_cnt] <= carry_in[bk*MXPATC +: MXPATC];
        end
        edge_cnt <= edge_cnt + 1;
    end

    task automatic cmp_dut(input string nm, input int lat, input logic v, input logic f,
                           input logic [6:0] p, input logic [4:0] k, input logic [11:0] c);
        int m;
        int e;
        logic win_rst;
        m = edge_cnt - 1;
        if (m < 0 || m >= NE) return;
        if (h_rst[m]) begin
            chk({nm, "_reset"}, {38'd0, v, f, p, k, c}, 64'd0);
            return;
        end
        e = m - lat + 1;
        if (e < 0) return;
        win_rst = 1'b0;
        for (int j = e; j < m; j++) if (h_rst[j]) win_rst = 1'b1;
        if (win_rst)
            chk({nm, "_flushed_valid"}, {63'd0, v}, 64'd0);
        else
            chk({nm, "_result"}, {38'd0, v, f, p, k, c},
                {38'd0, h_vld[e], h_fnd[e], h_pat[e], h_key[e], h_car[e]});
    endtask

    always @(negedge clock) begin
        cmp_dut("stream_a", LA, a_valid, a_found, a_pat, a_key, a_carry);
        cmp_dut("stream_b", LB, b_valid, b_found, b_pat, b_key, b_carry);
    end

    task automatic put(input int k, input logic [6:0] p, input logic [11:0] c);
        pat_in[k*MXPATB +: MXPATB]   = p;
        carry_in[k*MXPATC +: MXPATC] = c;
    endtask

    task automatic clr();
        pat_in   = '0;
        carry_in = '0;
    endtask

    initial begin
        logic [5:0] q6;
        int mode;
        repeat (3) @(negedge clock);
        chk("reset_state_a", {38'd0, a_valid, a_found, a_pat, a_key, a_carry}, 64'd0);
        chk("reset_state_b", {38'd0, b_valid, b_found, b_pat, b_key, b_carry}, 64'd0);

        // Single winner at key 19.
        reset = 1'b0; clr(); put(19, 7'h3C, 12'hABC); in_valid = 1'b1; thresh = 6'd0; tie_hi = 1'b0;
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock);
        chk("key19_a", {38'd0, a_valid, a_found, a_pat, a_key, a_carry},
            {38'd0, 1'b1, 1'b1, 7'h3C, 5'd19, 12'hABC});

        // Equal quality at keys 5 and 27, tie mode switched between consecutive sets.
        clr(); put(5, 7'h3C, 12'h005); put(27, 7'h3C, 12'h027); in_valid = 1'b1; tie_hi = 1'b0;
        @(negedge clock); tie_hi = 1'b1;
        @(negedge clock);
        chk("tie_lo_key", {59'd0, a_key}, 64'd5);
        in_valid = 1'b0; tie_hi = 1'b0;
        @(negedge clock);
        chk("tie_hi_key", {59'd0, a_key}, 64'd27);

        // Keys 8 and 9 differ only in the ignored lsb.
        clr(); put(8, 7'h3D, 12'h008); put(9, 7'h3C, 12'h009); in_valid = 1'b1; tie_hi = 1'b0;
        @(negedge clock); tie_hi = 1'b1;
        @(negedge clock);
        chk("lsb_ignored_lo", {52'd0, a_key, a_pat}, {52'd0, 5'd8, 7'h3D});
        in_valid = 1'b0; tie_hi = 1'b0;
        @(negedge clock);
        chk("lsb_ignored_hi", {52'd0, a_key, a_pat}, {52'd0, 5'd9, 7'h3C});

        // Threshold boundary: quality 29 then 30 against thresh 30.
        clr(); put(3, 7'h3B, 12'h111); thresh = 6'd30; in_valid = 1'b1;
        @(negedge clock); clr(); put(3, 7'h3C, 12'h222);
        @(negedge clock);
        chk("thresh_below", {62'd0, a_valid, a_found}, {62'd0, 1'b1, 1'b0});
        in_valid = 1'b0; thresh = 6'd0;
        @(negedge clock);
        chk("thresh_equal", {62'd0, a_valid, a_found}, {62'd0, 1'b1, 1'b1});

        // Back-to-back sets through the fully registered instance.
        clr(); put(0, 7'h3C, 12'h100); in_valid = 1'b1;
        @(negedge clock); clr(); put(31, 7'h3C, 12'h131);
        @(negedge clock); clr(); put(16, 7'h3C, 12'h116);
        @(negedge clock); in_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("b2b_first", {58'd0, b_valid, b_key}, {58'd0, 1'b1, 5'd0});
        @(negedge clock);
        chk("b2b_second", {58'd0, b_valid, b_key}, {58'd0, 1'b1, 5'd31});
        @(negedge clock);
        chk("b2b_third", {58'd0, b_valid, b_key}, {58'd0, 1'b1, 5'd16});

        // Reset with two sets in flight.
        clr(); put(7, 7'h3C, 12'h007); in_valid = 1'b1;
        @(negedge clock); clr(); put(9, 7'h3C, 12'h009);
        @(negedge clock); reset = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        chk("midrst_zero_a", {38'd0, a_valid, a_found, a_pat, a_key, a_carry}, 64'd0);
        chk("midrst_zero_b", {38'd0, b_valid, b_found, b_pat, b_key, b_carry}, 64'd0);
        reset = 1'b0; clr(); put(12, 7'h3C, 12'h012); in_valid = 1'b1;
        @(negedge clock); in_valid = 1'b0;
        chk("midrst_a_idle", {63'd0, a_valid}, 64'd0);
        for (int j = 5; j <= 9; j++) begin
            @(negedge clock);
            if (j == 5) chk("midrst_a_next", {58'd0, a_valid, a_key}, {58'd0, 1'b1, 5'd12});
            if (j < 9)  chk("midrst_b_idle", {63'd0, b_valid}, 64'd0);
            else        chk("midrst_b_next", {58'd0, b_valid, b_key}, {58'd0, 1'b1, 5'd12});
        end

        // Randomized stream, checked every cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            reset    = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            tie_hi   = 1'($urandom_range(0, 1));
            thresh   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            mode     = $urandom_range(0, 2);
            for (int k = 0; k < NIN; k++) begin
                if (mode == 0)      q6 = 6'($urandom_range(0, 3));
                else if (mode == 1) q6 = 6'($urandom_range(0, 63));
                else                q6 = ($urandom_range(0, 7) == 0) ? 6'd40 : 6'($urandom_range(0, 39));
                put(k, {q6, 1'($urandom_range(0, 1))}, 12'($urandom_range(0, 4095)));
            end
        end
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
